// File: rtl/tinyalu_pipe.sv
// Parametrised tiny ALU: single-cycle logic/add ops, counter-timed MUL/INC with busy.
// Optional zero/carry status outputs are enabled by defining TINYALU_STATUS_EN.
module tinyalu_pipe #(
    parameter int WIDTH       = 8,
    parameter int MUL_LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           opcode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   result,
    output logic                 done,
    output logic                 busy
`ifdef TINYALU_STATUS_EN
    ,
    output logic                 zero,
    output logic                 carry
`endif
);

    localparam int CW = $clog2(MUL_LATENCY);

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_NOT = 3'd6;
    localparam logic [2:0] OP_INC = 3'd7;

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [2*WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic [2:0]             op_q, op_d;
`ifdef TINYALU_STATUS_EN
    logic                   zero_q, zero_d;
    logic                   carry_q, carry_d;
`endif

    logic accept;
    logic is_multi;
    logic finish;

    // NOP keeps the previous result, so the held value is passed in.
    function automatic logic [2*WIDTH-1:0] alu_result(
        input logic [2:0]         op,
        input logic [WIDTH-1:0]   a,
        input logic [WIDTH-1:0]   b,
        input logic [2*WIDTH-1:0] prev
    );
        logic [WIDTH:0]       sum;
        logic [2*WIDTH-1:0]   res;
        sum = '0;
        res = prev;
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                res = {{(WIDTH-1){1'b0}}, sum};
            end
            OP_INC: begin
                sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, 1'b1};
                res = {{(WIDTH-1){1'b0}}, sum};
            end
            OP_AND:  res = {{WIDTH{1'b0}}, a & b};
            OP_XOR:  res = {{WIDTH{1'b0}}, a ^ b};
            OP_SUB:  res = {{WIDTH{1'b0}}, a - b};
            OP_NOT:  res = {{WIDTH{1'b0}}, ~a};
            OP_MUL:  res = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
            default: res = prev;
        endcase
        return res;
    endfunction

`ifdef TINYALU_STATUS_EN
    // Carry out for ADD/INC, borrow for SUB, cleared for everything else.
    function automatic logic alu_carry(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0] sum;
        logic           cy;
        sum = '0;
        cy  = 1'b0;
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                cy  = sum[WIDTH];
            end
            OP_INC: begin
                sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, 1'b1};
                cy  = sum[WIDTH];
            end
            OP_SUB:  cy = (a < b);
            default: cy = 1'b0;
        endcase
        return cy;
    endfunction
`endif

    assign accept   = start && !busy_q;
    assign is_multi = (opcode == OP_MUL) || (opcode == OP_INC);
    assign finish   = (state_q == ST_WAIT) && (cnt_q == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
`ifdef TINYALU_STATUS_EN
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
`ifdef TINYALU_STATUS_EN
            zero_q   <= zero_d;
            carry_q  <= carry_d;
`endif
        end
    end

    // Captured operands are pure data and carry no reset.
    always_ff @(posedge clk) begin
        a_q  <= a_d;
        b_q  <= b_d;
        op_q <= op_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && is_multi) begin
                    state_d = ST_WAIT;
                    cnt_d   = CW'(MUL_LATENCY - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == CW'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // accept and finish are exclusive: accept needs busy low, finish needs WAIT.
    always_comb begin
        busy_d   = (state_d == ST_WAIT);
        done_d   = 1'b0;
        result_d = result_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
`ifdef TINYALU_STATUS_EN
        zero_d   = zero_q;
        carry_d  = carry_q;
`endif
        if (accept) begin
            a_d  = A;
            b_d  = B;
            op_d = opcode;
            if (!is_multi) begin
                done_d   = 1'b1;
                result_d = alu_result(opcode, A, B, result_q);
`ifdef TINYALU_STATUS_EN
                zero_d   = (result_d == '0);
                carry_d  = alu_carry(opcode, A, B);
`endif
            end
        end else if (finish) begin
            done_d   = 1'b1;
            result_d = alu_result(op_q, a_q, b_q, result_q);
`ifdef TINYALU_STATUS_EN
            zero_d   = (result_d == '0);
            carry_d  = alu_carry(op_q, a_q, b_q);
`endif
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;
`ifdef TINYALU_STATUS_EN
    assign zero   = zero_q;
    assign carry  = carry_q;
`endif

endmodule

// File: tb/tb_tinyalu_pipe.sv
// Scoreboard bench for tinyalu_pipe: driver pushes expected completions, monitor pops on done.
module tb_tinyalu_pipe;
    localparam int W = 8;
    localparam int L = 3;
    localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [2:0]       opcode;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic [2*W-1:0]   result;
    logic             done;
    logic             busy;
`ifdef TINYALU_STATUS_EN
    logic             zero;
    logic             carry;
`endif

    always #5 clk = ~clk;

    tinyalu_pipe #(.WIDTH(W), .MUL_LATENCY(L)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .opcode (opcode),
        .A      (A),
        .B      (B),
        .result (result),
        .done   (done),
        .busy   (busy)
`ifdef TINYALU_STATUS_EN
        ,
        .zero   (zero),
        .carry  (carry)
`endif
    );

    typedef struct {
        longint unsigned res;
        bit              cy;
        bit              zr;
        int              due;
    } exp_t;

    exp_t            sb[$];
    int              checks = 0;
    int              failures = 0;
    int              edge_cnt = 0;
    int              next_free = 0;
    longint unsigned model_last = 0;
    bit              mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, req, edge_cnt);
        end
    endtask

    // Reference behaviour straight from the arithmetic definitions.
    function automatic exp_t model(input int op, input longint unsigned a, input longint unsigned b, input int due);
        exp_t e;
        e.cy  = 1'b0;
        e.due = due;
        case (op)
            1:       begin e.res = a + b;       e.cy = ((e.res >> W) & 1) != 0; end
            2:       e.res = a & b;
            3:       e.res = a ^ b;
            4:       e.res = a * b;
            5:       begin e.res = (a - b) & MASK; e.cy = (a < b); end
            6:       e.res = (~a) & MASK;
            7:       begin e.res = a + b + 1;   e.cy = ((e.res >> W) & 1) != 0; end
            default: e.res = model_last;
        endcase
        e.zr = (e.res == 0);
        return e;
    endfunction

    task automatic cyc(input bit r, input bit s, input int op, input int a, input int b);
        exp_t e;
        bit   multi;
        reset  = r;
        start  = s;
        opcode = op[2:0];
        A      = a[W-1:0];
        B      = b[W-1:0];
        multi  = (op == 4) || (op == 7);
        @(posedge clk);
        edge_cnt++;
        if (r) begin
            sb.delete();
            model_last = 0;
            next_free  = edge_cnt + 1;
        end else if (s && edge_cnt >= next_free) begin
            e = model(op, longint'(a & int'(MASK)), longint'(b & int'(MASK)),
                      multi ? edge_cnt + L - 1 : edge_cnt);
            sb.push_back(e);
            model_last = e.res;
            next_free  = edge_cnt + (multi ? L : 1);
        end
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_result"}, 64'(result), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
`ifdef TINYALU_STATUS_EN
        check({tag, "_zero"}, 64'(zero), 64'd0);
        check({tag, "_carry"}, 64'(carry), 64'd0);
`endif
    endtask

    // Monitor: busy against the model's occupancy window, done against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("busy", 64'(busy), 64'(edge_cnt <= next_free - 2));
                while (sb.size() > 0 && sb[0].due < edge_cnt) begin
                    checks++;
                    failures++;
                    $display("FAIL missing_done: got no done expected done at edge %0d (now %0d)", sb[0].due, edge_cnt);
                    void'(sb.pop_front());
                end
                if (done === 1'b1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done: got done=1 expected 0 at edge %0d", edge_cnt);
                    end else begin
                        e = sb.pop_front();
                        check("done_edge", 64'(edge_cnt), 64'(e.due));
                        check("result", 64'(result), 64'(e.res));
`ifdef TINYALU_STATUS_EN
                        check("zero", 64'(zero), 64'(e.zr));
                        check("carry", 64'(carry), 64'(e.cy));
`endif
                    end
                end else if (done !== 1'b0) begin
                    check("done_known", 64'(done), 64'd0);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r_op, r_a, r_b;
        bit r_s, r_r;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 3, 4);
        check_reset_state("reset");
        mon_en = 1'b1;

        // ADD with carry out, then a NOP that must keep it.
        cyc(0, 1, 1, 'hFF, 'h01);
        cyc(0, 1, 0, 'h12, 'h34);
        cyc(0, 0, 0, 0, 0);

        // MUL with operands scrambled while busy.
        cyc(0, 1, 4, 'hFF, 'hFF);
        for (int i = 0; i < L; i++) cyc(0, 0, $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255));

        // start+ADD during busy is dropped; a fresh start after busy works.
        cyc(0, 1, 4, 'h0C, 'h0D);
        for (int i = 0; i < L - 1; i++) cyc(0, 1, 1, 3, 4);
        cyc(0, 0, 1, 3, 4);
        cyc(0, 1, 1, 3, 4);
        cyc(0, 0, 0, 0, 0);

        // Reset on the edge a MUL would have completed.
        cyc(0, 1, 4, 'h21, 'h03);
        for (int i = 0; i < L - 2; i++) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check_reset_state("abort");
        cyc(0, 1, 1, 3, 4);
        cyc(0, 0, 0, 0, 0);
        check("add_after_abort", 64'(result), 64'd7);

        // Back-to-back single-cycle ops.
        cyc(0, 1, 5, 'h02, 'h03);
        cyc(0, 1, 3, 'hF0, 'hFF);
        cyc(0, 1, 6, 'h0F, 'h00);
        cyc(0, 0, 0, 0, 0);

        // Zero / carry corners, plus INC wrapping into bit WIDTH.
        cyc(0, 1, 5, 5, 5);
        cyc(0, 1, 7, 'hFF, 'h00);
        for (int i = 0; i < L; i++) cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 2, 'hAA, 'h0F);
        cyc(0, 1, 0, 0, 0);

        for (int i = 0; i < 2000; i++) begin
            r_r  = ($urandom_range(0, 99) == 0);
            r_s  = ($urandom_range(0, 99) < 70);
            r_op = $urandom_range(0, 7);
            r_a  = ($urandom_range(0, 7) == 0) ? 'hFF : $urandom_range(0, 255);
            r_b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            cyc(r_r, r_s, r_op, r_a, r_b);
        end

        for (int i = 0; i < L + 2; i++) cyc(0, 0, 0, 0, 0);
        check("queue_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
